// File: rtl/fwft_pkt_pkg.sv
// fwft_pkt_pkg: shared types and constants for the FWFT packet reader.
//   state_t          : reader FSM states (IDLE, STREAM, DISCARD)
//   EOP_BIT          : end-of-packet marker position in a FIFO word
//   DEF_DATA_W       : default data byte width
//   DEF_MAX_PKT_LEN  : default maximum forwarded bytes per packet
//   DEF_LEN_W        : default byte-in-packet counter width
//   PKT_CNT_W        : forwarded-packet statistics counter width
//   ERR_CNT_W        : truncated-packet statistics counter width
package fwft_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam int unsigned EOP_BIT         = 8;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_MAX_PKT_LEN = 16;
    localparam int unsigned DEF_LEN_W       = 8;
    localparam int unsigned PKT_CNT_W       = 16;
    localparam int unsigned ERR_CNT_W       = 8;

endpackage

// File: rtl/fwft_out_reg.sv
// fwft_out_reg: single-entry registered output stage (data, valid, last).
// Ports:
//   i_clk    : clock
//   i_reset  : synchronous active-high reset, clears all outputs
//   i_load   : capture i_data/i_last and raise o_valid
//   i_data   : byte to capture
//   i_last   : last-of-packet flag to capture
//   i_ready  : downstream ready; drops o_valid when nothing new is loaded
//   o_data   : registered byte
//   o_valid  : registered valid
//   o_last   : registered last flag
module fwft_out_reg
    import fwft_pkt_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (i_ready) begin
            // Beat accepted with no replacement: data/last are left as-is.
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/fwft_pkt_reader.sv
// fwft_pkt_reader: drains a first-word-fall-through FIFO of {eop, byte}
// words into a registered valid/ready byte stream, truncating packets
// longer than MAX_PKT_LEN and discarding their tail up to the next marker.
// Optional feature macro: FWFT_PKT_READER_STATS_EN
//   defined   -> PktCount / ErrCount saturating statistics counters
//   undefined -> PktCount / ErrCount tied to zero
// Ports:
//   Clk         : clock, shared with the FIFO read side
//   Reset       : synchronous active-high reset
//   Enable      : start/continue consumption, sampled at packet boundaries
//   FifoDout    : FWFT head word, bit DATA_W is the end-of-packet marker
//   FifoEmpty   : FIFO empty flag
//   FifoRdEn    : combinational pop of the head word
//   OutData     : registered output byte
//   OutValid    : OutData/OutLast valid
//   OutLast     : last byte of packet (marker or truncation)
//   OutReady    : downstream ready
//   OverflowErr : one-cycle pulse, aligned with the truncating beat
//   PktCount    : forwarded packets (saturating)
//   ErrCount    : truncated packets (saturating)
module fwft_pkt_reader
    import fwft_pkt_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned MAX_PKT_LEN = DEF_MAX_PKT_LEN,
    parameter int unsigned LEN_W       = DEF_LEN_W
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [DATA_W:0]      FifoDout,
    input  logic                 FifoEmpty,
    output logic                 FifoRdEn,
    output logic [DATA_W-1:0]    OutData,
    output logic                 OutValid,
    output logic                 OutLast,
    input  logic                 OutReady,
    output logic                 OverflowErr,
    output logic [PKT_CNT_W-1:0] PktCount,
    output logic [ERR_CNT_W-1:0] ErrCount
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;
    logic             r_ovf;

    logic             w_marker;
    logic             w_out_valid;
    logic             w_rd_en;
    logic             w_load;
    logic             w_last;
    logic             w_eop;
    logic             w_trunc;

    assign w_marker = FifoDout[DATA_W];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_ovf   <= w_trunc;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_rd_en     = 1'b0;
        w_load      = 1'b0;
        w_last      = 1'b0;
        w_eop       = 1'b0;
        w_trunc     = 1'b0;
        case (r_state)
            IDLE: begin
                if (Enable) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                // Load only when the output slot is empty or being drained.
                if (!FifoEmpty && (!w_out_valid || OutReady)) begin
                    w_rd_en   = 1'b1;
                    w_load    = 1'b1;
                    w_len_nxt = r_len + 1'b1;
                    if (w_marker) begin
                        w_last      = 1'b1;
                        w_eop       = 1'b1;
                        w_len_nxt   = '0;
                        w_state_nxt = Enable ? STREAM : IDLE;
                    end else if (r_len == LEN_W'(MAX_PKT_LEN - 1)) begin
                        w_last      = 1'b1;
                        w_trunc     = 1'b1;
                        w_state_nxt = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (!FifoEmpty) begin
                    w_rd_en = 1'b1;
                    if (w_marker) begin
                        w_len_nxt   = '0;
                        w_state_nxt = Enable ? STREAM : IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    fwft_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_load  (w_load),
        .i_data  (FifoDout[DATA_W-1:0]),
        .i_last  (w_last),
        .i_ready (OutReady),
        .o_data  (OutData),
        .o_valid (w_out_valid),
        .o_last  (OutLast)
    );

    assign OutValid    = w_out_valid;
    assign FifoRdEn    = w_rd_en;
    assign OverflowErr = r_ovf;

`ifdef FWFT_PKT_READER_STATS_EN
    logic [PKT_CNT_W-1:0] r_pkt_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            // A truncated packet still counts as forwarded.
            if ((w_eop || w_trunc) && (r_pkt_cnt != '1)) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
            if (w_trunc && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign PktCount = r_pkt_cnt;
    assign ErrCount = r_err_cnt;
`else
    assign PktCount = '0;
    assign ErrCount = '0;
`endif

endmodule

// File: tb/tb_fwft_pkt_reader.sv
// tb_fwft_pkt_reader: directed self-checking bench for fwft_pkt_reader,
// with a small FWFT FIFO model feeding the reader.
module tb_fwft_pkt_reader;

`ifdef FWFT_PKT_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        Enable;
    logic [8:0]  FifoDout;
    logic        FifoEmpty;
    logic        FifoRdEn;
    logic [7:0]  OutData;
    logic        OutValid;
    logic        OutLast;
    logic        OutReady;
    logic        OverflowErr;
    logic [15:0] PktCount;
    logic [7:0]  ErrCount;

    int checks   = 0;
    int failures = 0;

    logic [8:0] mem [64];
    int head = 0;
    int tail = 0;
    int pops = 0;

    assign FifoEmpty = (head == tail);
    assign FifoDout  = mem[head % 64];

    always @(posedge Clk) begin
        if (FifoRdEn && (head != tail)) begin
            head <= head + 1;
            pops <= pops + 1;
        end
    end

    fwft_pkt_reader #(
        .DATA_W      (8),
        .MAX_PKT_LEN (16),
        .LEN_W       (8)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .FifoDout    (FifoDout),
        .FifoEmpty   (FifoEmpty),
        .FifoRdEn    (FifoRdEn),
        .OutData     (OutData),
        .OutValid    (OutValid),
        .OutLast     (OutLast),
        .OutReady    (OutReady),
        .OverflowErr (OverflowErr),
        .PktCount    (PktCount),
        .ErrCount    (ErrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] w);
        mem[tail % 64] = w;
        tail = tail + 1;
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    // Advance one clock and check the output register contents.
    task automatic beat(input string tag, input bit v, input logic [7:0] d,
                        input bit l, input bit ovf);
        step();
        chk({tag, "_valid"}, 32'(OutValid), 32'(v));
        if (v) begin
            chk({tag, "_data"}, 32'(OutData), 32'(d));
            chk({tag, "_last"}, 32'(OutLast), 32'(l));
        end
        chk({tag, "_ovf"}, 32'(OverflowErr), 32'(ovf));
    endtask

    task automatic chk_stats(input string tag, input int pkt, input int err);
        chk({tag, "_pktcount"}, 32'(PktCount), STATS ? 32'(pkt) : 32'd0);
        chk({tag, "_errcount"}, 32'(ErrCount), STATS ? 32'(err) : 32'd0);
    endtask

    initial begin
        Reset    = 1'b1;
        Enable   = 1'b0;
        OutReady = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_valid", 32'(OutValid), 32'd0);
        chk("rst_data",  32'(OutData),  32'd0);
        chk("rst_last",  32'(OutLast),  32'd0);
        chk("rst_ovf",   32'(OverflowErr), 32'd0);
        chk_stats("rst", 0, 0);
        Reset = 1'b0;

        // 3-byte packet, full throughput
        push(9'h011); push(9'h022); push(9'h133);
        Enable = 1'b1;
        #1;
        chk("t1_idle_rden", 32'(FifoRdEn), 32'd0);
        beat("t1_enter", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_stream_rden", 32'(FifoRdEn), 32'd1);
        beat("t1_b1", 1'b1, 8'h11, 1'b0, 1'b0);
        beat("t1_b2", 1'b1, 8'h22, 1'b0, 1'b0);
        beat("t1_b3", 1'b1, 8'h33, 1'b1, 1'b0);
        chk_stats("t1", 1, 0);
        beat("t1_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Same packet with a 4-clock stall on beat 2
        push(9'h011); push(9'h022); push(9'h133);
        beat("t2_b1", 1'b1, 8'h11, 1'b0, 1'b0);
        beat("t2_b2", 1'b1, 8'h22, 1'b0, 1'b0);
        OutReady = 1'b0;
        #1;
        chk("t2_stall_rden0", 32'(FifoRdEn), 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat("t2_hold", 1'b1, 8'h22, 1'b0, 1'b0);
            chk("t2_stall_rden", 32'(FifoRdEn), 32'd0);
        end
        OutReady = 1'b1;
        #1;
        chk("t2_resume_rden", 32'(FifoRdEn), 32'd1);
        beat("t2_b3", 1'b1, 8'h33, 1'b1, 1'b0);
        beat("t2_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_pops", 32'(pops), 32'd6);
        chk_stats("t2", 2, 0);

        // 20-byte packet: truncated at 16, bytes 17..20 discarded
        for (int i = 1; i <= 20; i++) begin
            push({(i == 20), 8'(8'h40 + i)});
        end
        for (int i = 1; i <= 16; i++) begin
            beat("t3_beat", 1'b1, 8'(8'h40 + i), (i == 16), (i == 16));
        end
        chk_stats("t3_trunc", 3, 1);
        for (int i = 0; i < 4; i++) begin
            beat("t3_discard", 1'b0, 8'h00, 1'b0, 1'b0);
            chk("t3_discard_hold", 32'(OutData), 32'h50);
        end
        chk("t3_pops", 32'(pops), 32'd26);
        chk("t3_empty", 32'(FifoEmpty), 32'd1);
        chk_stats("t3", 3, 1);

        // Single-byte packet, then exactly MAX_PKT_LEN bytes
        push(9'h1AA);
        for (int i = 1; i <= 16; i++) begin
            push({(i == 16), 8'(8'h60 + i)});
        end
        beat("t4_single", 1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            beat("t4_beat", 1'b1, 8'(8'h60 + i), (i == 16), 1'b0);
        end
        beat("t4_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        chk_stats("t4", 5, 1);

        // Enable dropped during byte 2: packet completes, next head stays
        push(9'h071); push(9'h072); push(9'h073); push(9'h174); push(9'h0F5);
        beat("t5_b1", 1'b1, 8'h71, 1'b0, 1'b0);
        Enable = 1'b0;
        beat("t5_b2", 1'b1, 8'h72, 1'b0, 1'b0);
        beat("t5_b3", 1'b1, 8'h73, 1'b0, 1'b0);
        beat("t5_b4", 1'b1, 8'h74, 1'b1, 1'b0);
        chk("t5_idle_rden0", 32'(FifoRdEn), 32'd0);
        beat("t5_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_idle_rden1", 32'(FifoRdEn), 32'd0);
        chk("t5_pops", 32'(pops), 32'd47);
        chk("t5_not_empty", 32'(FifoEmpty), 32'd0);
        chk_stats("t5", 6, 1);

        // Reset mid-packet, then a fresh 16-byte packet must not truncate
        push(9'h0F6); push(9'h0F7);
        Enable = 1'b1;
        beat("t6_enter", 1'b0, 8'h00, 1'b0, 1'b0);
        beat("t6_b1", 1'b1, 8'hF5, 1'b0, 1'b0);
        beat("t6_b2", 1'b1, 8'hF6, 1'b0, 1'b0);
        OutReady = 1'b0;
        Reset    = 1'b1;
        step();
        chk("t6_rst_valid", 32'(OutValid), 32'd0);
        chk("t6_rst_data",  32'(OutData),  32'd0);
        chk("t6_rst_last",  32'(OutLast),  32'd0);
        chk("t6_rst_rden",  32'(FifoRdEn), 32'd0);
        chk_stats("t6_rst", 0, 0);
        Reset    = 1'b0;
        OutReady = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            push({(i == 15), 8'(8'h80 + i)});
        end
        beat("t6_enter2", 1'b0, 8'h00, 1'b0, 1'b0);
        beat("t6_first", 1'b1, 8'hF7, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            beat("t6_beat", 1'b1, 8'(8'h80 + i), (i == 15), 1'b0);
        end
        beat("t6_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_pops", 32'(pops), 32'd65);
        chk("t6_empty", 32'(FifoEmpty), 32'd1);
        chk_stats("t6", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
